// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared types and constants for the blink timer bank
package blink_pkg;

  typedef enum logic {ST_IDLE, ST_RUN} tmr_state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler producing a registered one-clock tick
module tick_gen #(
  parameter int PRESC_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PRESC_W-1:0] i_presc,
  output logic               o_tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic               wrap;

  // >= so a divisor lowered below the current count wraps on the next clock
  always_comb begin
    wrap   = (cnt_q >= i_presc);
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    tick_d = wrap;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/tmr_channel.sv
// rtl/tmr_channel.sv - one timer channel: periodic/one-shot count of ticks with blink toggle
module tmr_channel
  import blink_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_mode,
  input  logic [CNT_W-1:0] i_period,
  output logic             o_busy,
  output logic             o_timeout,
  output logic             o_blink,
  output logic [CNT_W-1:0] o_count
);

  tmr_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             blink_q, blink_d;
  logic             timeout_q, timeout_d;
  logic             start_ok;
  logic             terminal;

  assign start_ok = i_start && (i_period != '0);
  assign terminal = i_tick && (count_q == period_q - 1'b1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      period_q  <= '0;
      mode_q    <= MODE_PERIODIC;
      blink_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      period_q  <= period_d;
      mode_q    <= mode_d;
      blink_q   <= blink_d;
      timeout_q <= timeout_d;
    end
  end

  // Priority: stop, then (re)start, then counting; a restart suppresses a coinciding terminal tick
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    period_d  = period_q;
    mode_d    = mode_q;
    blink_d   = blink_q;
    timeout_d = 1'b0;
    if (i_stop) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (start_ok) begin
      state_d  = ST_RUN;
      count_d  = '0;
      period_d = i_period;
      mode_d   = i_mode;
      blink_d  = 1'b0;
    end else if (state_q == ST_RUN && i_tick) begin
      if (terminal) begin
        count_d   = '0;
        timeout_d = 1'b1;
        blink_d   = ~blink_q;
        if (mode_q == MODE_ONESHOT) state_d = ST_IDLE;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_comb begin
    o_busy    = (state_q == ST_RUN);
    o_timeout = timeout_q;
    o_blink   = blink_q;
    o_count   = count_q;
  end

endmodule

// File: rtl/blink_timer_bank.sv
// rtl/blink_timer_bank.sv - bank of independent timer channels sharing one prescaler tick
module blink_timer_bank
  import blink_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [PRESC_W-1:0]      i_presc,
  input  logic [NUM_CH-1:0]       i_start,
  input  logic [NUM_CH-1:0]       i_stop,
  input  logic [NUM_CH-1:0]       i_mode,
  input  logic [NUM_CH*CNT_W-1:0] i_period,
  output logic [NUM_CH-1:0]       o_busy,
  output logic [NUM_CH-1:0]       o_timeout,
  output logic [NUM_CH-1:0]       o_blink,
  output logic [NUM_CH*CNT_W-1:0] o_count
);

  logic tick;

  tick_gen #(.PRESC_W(PRESC_W)) u_tick_gen (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_presc (i_presc),
    .o_tick  (tick)
  );

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    tmr_channel #(.CNT_W(CNT_W)) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_tick    (tick),
      .i_start   (i_start[k]),
      .i_stop    (i_stop[k]),
      .i_mode    (i_mode[k]),
      .i_period  (i_period[k*CNT_W +: CNT_W]),
      .o_busy    (o_busy[k]),
      .o_timeout (o_timeout[k]),
      .o_blink   (o_blink[k]),
      .o_count   (o_count[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_blink_timer_bank.sv
// tb/tb_blink_timer_bank.sv - scoreboard bench for blink_timer_bank against a tick-count reference model
module tb_blink_timer_bank;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int PW  = 16;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [PW-1:0]     i_presc = '0;
  logic [NCH-1:0]    i_start = '0;
  logic [NCH-1:0]    i_stop = '0;
  logic [NCH-1:0]    i_mode = '0;
  logic [NCH*CW-1:0] i_period = '0;
  logic [NCH-1:0]    o_busy, o_timeout, o_blink;
  logic [NCH*CW-1:0] o_count;

  blink_timer_bank #(.NUM_CH(NCH), .CNT_W(CW), .PRESC_W(PW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_presc(i_presc), .i_start(i_start),
    .i_stop(i_stop), .i_mode(i_mode), .i_period(i_period), .o_busy(o_busy),
    .o_timeout(o_timeout), .o_blink(o_blink), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    to;
    logic [NCH-1:0]    blink;
    logic [NCH*CW-1:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference: each channel is "running for n ticks since start"; count = n mod P, timeout when n hits a multiple of P
  int m_clk_since_wrap;
  bit m_tick;
  bit m_run[NCH];
  int m_per[NCH];
  bit m_oneshot[NCH];
  int m_n[NCH];
  bit m_blink[NCH];
  bit m_to[NCH];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_clk_since_wrap = 0;
    m_tick = 0;
    for (int k = 0; k < NCH; k++) begin
      m_run[k] = 0; m_per[k] = 0; m_oneshot[k] = 0;
      m_n[k] = 0; m_blink[k] = 0; m_to[k] = 0;
    end
  endtask

  task automatic model_step();
    bit   tk;
    int   p;
    exp_t e;
    tk = m_tick;
    m_tick = (m_clk_since_wrap >= int'(i_presc));
    m_clk_since_wrap = m_tick ? 0 : m_clk_since_wrap + 1;
    for (int k = 0; k < NCH; k++) begin
      p = int'(i_period[k*CW +: CW]);
      m_to[k] = 0;
      if (i_stop[k]) begin
        m_run[k] = 0;
        m_n[k] = 0;
      end else if (i_start[k] && p != 0) begin
        m_run[k] = 1; m_per[k] = p; m_oneshot[k] = i_mode[k];
        m_n[k] = 0; m_blink[k] = 0;
      end else if (m_run[k] && tk) begin
        m_n[k]++;
        if (m_n[k] % m_per[k] == 0) begin
          m_to[k] = 1;
          m_blink[k] = ((m_n[k] / m_per[k]) % 2) == 1;
          if (m_oneshot[k]) begin
            m_run[k] = 0;
            m_n[k] = 0;
          end
        end
      end
      e.busy[k]  = m_run[k];
      e.to[k]    = m_to[k];
      e.blink[k] = m_blink[k];
      e.count[k*CW +: CW] = m_run[k] ? CW'(m_n[k] % m_per[k]) : '0;
    end
    exp_q.push_back(e);
  endtask

  // Drive one clock's worth of inputs, predict the resulting outputs, advance
  task automatic cyc(input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
    i_start = st;
    i_stop  = sp;
    model_step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    #1;
    check("rst_busy", 32'(o_busy), 0);
    check("rst_timeout", 32'(o_timeout), 0);
    check("rst_blink", 32'(o_blink), 0);
    check("rst_count", o_count, 0);
    model_reset();
    i_start = '0;
    i_stop = '0;
    repeat (2) @(posedge i_clk);
    #2;
    i_rst = 1'b0;
  endtask

  exp_t mon_e;
  always begin
    @(posedge i_clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("busy", 32'(o_busy), 32'(mon_e.busy));
      check("timeout", 32'(o_timeout), 32'(mon_e.to));
      check("blink", 32'(o_blink), 32'(mon_e.blink));
      check("count", o_count, mon_e.count);
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge i_clk);
    #2;
    check("init_busy", 32'(o_busy), 0);
    check("init_count", o_count, 0);
    i_rst = 1'b0;

    // reset mid-run
    i_presc = 0;
    i_mode = '0;
    i_period = {8'd0, 8'd0, 8'd0, 8'd5};
    cyc(4'b0001, '0);
    idle(3);
    do_reset();
    idle(10);

    // periodic ch1 P=3
    i_period = {8'd0, 8'd0, 8'd3, 8'd0};
    cyc(4'b0010, '0);
    idle(12);
    cyc('0, 4'b0010);

    // one-shot ch2 P=2 with prescaler
    i_presc = 2;
    i_mode = 4'b0100;
    i_period = {8'd0, 8'd2, 8'd0, 8'd0};
    cyc(4'b0100, '0);
    idle(50);

    // boundaries: P=0 ignored, P=1, P=255
    i_presc = 0;
    i_mode = '0;
    i_period = '0;
    cyc(4'b1000, '0);
    idle(2);
    i_period = {8'd1, 8'd0, 8'd0, 8'd0};
    cyc(4'b1000, '0);
    idle(5);
    cyc('0, 4'b1000);
    i_period = {8'd0, 8'd0, 8'd0, 8'd255};
    cyc(4'b0001, '0);
    idle(258);
    cyc('0, 4'b0001);

    // simultaneous events
    i_period = {8'd0, 8'd0, 8'd3, 8'd4};
    cyc(4'b0001, 4'b0001);
    idle(2);
    cyc(4'b0010, '0);
    idle(2);
    cyc('0, 4'b0010);
    idle(2);
    cyc(4'b0010, '0);
    idle(2);
    i_period = {8'd0, 8'd0, 8'd4, 8'd0};
    cyc(4'b0010, '0);
    idle(9);
    cyc('0, 4'b0010);

    // independence with mid-run period edits
    i_period = {8'd5, 8'd4, 8'd3, 8'd2};
    cyc(4'b1111, '0);
    idle(30);
    i_period = {8'd7, 8'd1, 8'd6, 8'd9};
    i_mode = 4'b1111;
    idle(32);
    cyc('0, 4'b1111);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      logic [NCH-1:0] st, sp;
      if ($urandom_range(0, 99) == 0) i_presc = PW'($urandom_range(0, 3));
      for (int k = 0; k < NCH; k++) begin
        i_period[k*CW +: CW] = CW'($urandom_range(0, 6));
        st[k] = ($urandom_range(0, 19) == 0);
        sp[k] = ($urandom_range(0, 39) == 0);
      end
      i_mode = NCH'($urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cyc(st, sp);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge i_clk);
    #2;
    check("drain", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
